// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU datapath control blocks.
//   TPU_DATA_WIDTH : default width of one weight word
//   wbuf_state_e   : weight-buffer load controller state encoding
package tpu_pkg;

    localparam int TPU_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } wbuf_state_e;

endpackage

// File: rtl/wbuf_load_ctrl_onehot_dec.sv
// Binary index to one-hot decoder with a fire gate.
//   idx    : binary row index
//   fire   : when low, the output is all zeros
//   onehot : ROWS-bit one-hot of idx (or zero)
module onehot_dec #(
    parameter int ROWS  = 4,
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             fire,
    output logic [ROWS-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            onehot[i] = fire && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/wbuf_load_ctrl.sv
// Weight-buffer load controller: steers a valid/ready word stream into
// ROWS enable-gated DFF rows, then runs a compute window of comp_len cycles
// and pulses done.
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a job (sampled in IDLE only); comp_len latched with it
//   abort     : return to IDLE from any busy state, no done pulse
//   in_valid/in_data/in_ready : upstream weight stream
//   row_en    : one-hot DFF enables, asserted only on a transfer
//   row_d     : data bus to every DFF d input
//   comp_en   : array compute enable
//   busy      : not IDLE
//   done      : one-cycle end-of-job pulse
module wbuf_load_ctrl
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = TPU_DATA_WIDTH,
    parameter int ROWS       = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  comp_len,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [ROWS-1:0]       row_en,
    output logic [DATA_WIDTH-1:0] row_d,
    output logic                  comp_en,
    output logic                  busy,
    output logic                  done
);

    localparam int PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(ROWS - 1);

    wbuf_state_e          state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic                 fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        in_ready = 1'b0;
        comp_en  = 1'b0;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = comp_len;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (ptr_q == LAST_ROW) begin
                        ptr_d   = '0;
                        cnt_d   = '0;
                        state_d = (len_q == '0) ? ST_DONE : ST_COMPUTE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                comp_en = 1'b1;
                if (cnt_q == len_q - 1'b1) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // in_ready is dropped with the enables on abort so the upstream
        // never sees a handshake that did not write a row.
        if (abort && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            ptr_d    = '0;
            cnt_d    = '0;
            in_ready = 1'b0;
            comp_en  = 1'b0;
            done     = 1'b0;
        end
    end

    assign fire  = in_valid & in_ready;
    assign busy  = (state_q != ST_IDLE);
    assign row_d = in_data;

    onehot_dec #(
        .ROWS  (ROWS),
        .IDX_W (PTR_W)
    ) u_row_dec (
        .idx    (ptr_q),
        .fire   (fire),
        .onehot (row_en)
    );

endmodule

// File: tb/tb_wbuf_load_ctrl.sv
// Directed bench for wbuf_load_ctrl with a 4-row DFF bank model.
module tb_wbuf_load_ctrl;

    localparam int DW   = 16;
    localparam int ROWS = 4;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst, start, abort, in_valid;
    logic [CW-1:0] comp_len;
    logic [DW-1:0] in_data;
    logic          in_ready, comp_en, busy, done;
    logic [ROWS-1:0] row_en;
    logic [DW-1:0] row_d;
    logic [DW-1:0] q [ROWS];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wbuf_load_ctrl #(
        .DATA_WIDTH (DW),
        .ROWS       (ROWS),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .comp_len (comp_len),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .row_en   (row_en),
        .row_d    (row_d),
        .comp_en  (comp_en),
        .busy     (busy),
        .done     (done)
    );

    for (genvar r = 0; r < ROWS; r++) begin : g_dff
        always_ff @(posedge clk) begin
            if (row_en[r]) q[r] <= row_d;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic start_job(input logic [CW-1:0] len);
        start    = 1'b1;
        comp_len = len;
        tick();
        start    = 1'b0;
    endtask

    task automatic load4(input string tag, input logic [DW-1:0] w [4]);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            settle();
            chk({tag, "_row_en"}, 32'(row_en), 32'(1 << i));
            chk({tag, "_ready"}, 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        settle();
    endtask

    // Entered settled in the first post-load cycle; counts comp_en cycles,
    // then checks the done pulse and the return to idle.
    task automatic run_compute(input string tag, input int exp_len);
        int n;
        n = 0;
        while (comp_en === 1'b1 && n < 300) begin
            if (in_ready === 1'b1 || row_en !== '0) begin
                chk({tag, "_comp_excl"}, {31'd0, in_ready}, 32'd0);
            end
            n++;
            tick();
            settle();
        end
        chk({tag, "_comp_cycles"}, 32'(n), 32'(exp_len));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd1);
        tick();
        settle();
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    logic [DW-1:0] w [4];

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        comp_len = '0; in_data = '0;
        tick(); tick();
        settle();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_row_en", 32'(row_en), 32'd0);
        chk("rst_comp_en", 32'(comp_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // Basic job: words 3,4,8,9 with comp_len=3.
        start_job(8'd3);
        w = '{16'd3, 16'd4, 16'd8, 16'd9};
        in_valid = 1'b1;
        load4("basic", w);
        run_compute("basic", 3);
        chk("basic_q0", 32'(q[0]), 32'd3);
        chk("basic_q1", 32'(q[1]), 32'd4);
        chk("basic_q2", 32'(q[2]), 32'd8);
        chk("basic_q3", 32'(q[3]), 32'd9);

        // Bubbled input: valid pattern 1,0,0,1,1,0,1.
        start_job(8'd2);
        begin
            logic [6:0] vpat;
            logic [3:0] exp_en [7];
            int n_en;
            vpat   = 7'b1011001;
            exp_en = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b1000};
            n_en = 0;
            for (int i = 0; i < 7; i++) begin
                in_valid = vpat[i];
                in_data  = 16'h0050 + 16'(i);
                settle();
                chk("bub_row_en", 32'(row_en), 32'(exp_en[i]));
                if (row_en != '0) n_en++;
                tick();
            end
            in_valid = 1'b0;
            settle();
            chk("bub_enables", 32'(n_en), 32'd4);
            chk("bub_compute_next", 32'(comp_en), 32'd1);
            run_compute("bub", 2);
            chk("bub_q1", 32'(q[1]), 32'h0053);
            chk("bub_q3", 32'(q[3]), 32'h0056);
        end

        // Zero-length job goes LOAD -> DONE.
        start_job(8'd0);
        w = '{16'hA0, 16'hA1, 16'hA2, 16'hA3};
        load4("zero", w);
        chk("zero_no_comp", 32'(comp_en), 32'd0);
        run_compute("zero", 0);

        // Abort in LOAD after two transfers.
        start_job(8'd2);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hB0 + 16'(i);
            settle();
            tick();
        end
        abort = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF;
        settle();
        chk("abort_row_en", 32'(row_en), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd0);
        tick();
        abort = 1'b0; in_valid = 1'b0;
        settle();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_q0", 32'(q[0]), 32'hB0);
        chk("abort_q1", 32'(q[1]), 32'hB1);
        chk("abort_q2", 32'(q[2]), 32'hA2);
        chk("abort_q3", 32'(q[3]), 32'hA3);
        tick();
        start_job(8'd1);
        w = '{16'hC0, 16'hC1, 16'hC2, 16'hC3};
        load4("post_abort", w);
        run_compute("post_abort", 1);

        // Reset mid-COMPUTE at counter=1, comp_len=5.
        start_job(8'd5);
        load4("rstc", w);
        chk("rstc_comp0", 32'(comp_en), 32'd1);
        tick();
        rst = 1'b1; start = 1'b1;
        settle();
        tick();
        rst = 1'b0; start = 1'b0;
        settle();
        chk("rstc_busy", 32'(busy), 32'd0);
        chk("rstc_comp_en", 32'(comp_en), 32'd0);
        chk("rstc_ready", 32'(in_ready), 32'd0);
        chk("rstc_done", 32'(done), 32'd0);
        tick();
        settle();
        chk("rstc_start_ignored", 32'(busy), 32'd0);
        start_job(8'd5);
        load4("rstc2", w);
        run_compute("rstc2", 5);

        // start held through DONE; comp_len changed after start.
        start = 1'b1; comp_len = 8'd2;
        tick();
        comp_len = 8'd7;
        load4("hold", w);
        run_compute("hold", 2);
        tick();
        settle();
        chk("hold_new_job", 32'(busy), 32'd1);
        abort = 1'b1; start = 1'b0;
        tick();
        abort = 1'b0;
        settle();
        chk("hold_abort_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wbuf_load_ctrl.md
Name: wbuf_load_ctrl

Overview:
- Sequencer for the enable-gated DFF weight-buffer bank that feeds the systolic array: ROWS registers of DATA_WIDTH, one per array row.
- Accepts a stream of weight words over a valid/ready handshake and steers each word into the next row by raising exactly one row enable.
- Once all rows are loaded, it runs the compute window for a programmable number of cycles, then pulses done.
- Sits between the input fetch unit (upstream) and the weight DFF bank plus array compute enable (downstream).

Parameters:
- DATA_WIDTH, 16, width of one weight word.
- ROWS, 4, number of buffer rows (DFF instances) to load; ≥2.
- CNT_WIDTH, 8, width of the compute-length counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a load/compute job; sampled only in IDLE.
- comp_len  input  CNT_WIDTH  compute-window length in cycles; latched on accepted start.
- abort  input  1  return to IDLE at next edge from any state.
- in_valid  input  1  upstream word valid.
- in_data  input  DATA_WIDTH  upstream weight word.
- in_ready  output  1  controller can accept a word this cycle.
- row_en  output  ROWS  one-hot DFF enables, combinational from state and handshake.
- row_d  output  DATA_WIDTH  data bus to all DFF d inputs (= in_data).
- comp_en  output  1  array compute enable.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at the end of the compute window.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, row pointer=0, compute counter=0, latched length=0. All outputs 0: in_ready, row_en, comp_en, busy, done. Reset overrides abort and start.
- States: IDLE, LOAD, COMPUTE, DONE.
- IDLE
  - start=1: latch comp_len, pointer←0, go to LOAD.
  - start=1 with comp_len=0: still go to LOAD; COMPUTE is then skipped (LOAD→DONE).
- LOAD
  - in_ready=1.
  - Transfer occurs when in_valid&in_ready.
  - On a transfer: row_en[pointer]=1 in that same cycle (zero-latency steer; DFF captures at the edge) and pointer increments.
  - No transfer: row_en=0, pointer holds.
  - Transfer at pointer=ROWS-1: pointer wraps to 0 and state goes to COMPUTE (or DONE if latched length=0).
- COMPUTE
  - comp_en=1, in_ready=0, row_en=0.
  - Counter loads 0 on entry and increments each cycle.
  - When counter = latched length−1, go to DONE.
  - comp_en is therefore high for exactly comp_len cycles.
- DONE
  - done=1 for exactly one cycle, busy=1, then IDLE.
  - A start asserted during DONE is ignored; start is sampled only in IDLE.
- abort
  - In any non-IDLE state: next state IDLE, pointer and counter cleared.
  - row_en and comp_en are forced 0 in the abort cycle.
  - done is not pulsed; rows already written keep their contents, because the controller never clears the DFFs.
- Invariants
  - row_en is one-hot or zero, never multi-hot.
  - row_en≠0 only when in_valid&in_ready.
  - comp_en and in_ready are never high together.
- Latched length is unaffected by comp_len changes after start.
- Counter width: CNT_WIDTH; comp_len=2^CNT_WIDTH−1 is the maximum window.

Decomposition:
- Shared package (tpu_pkg) holds:
  - State encoding typedef/localparams: ST_IDLE=2'd0, ST_LOAD=2'd1, ST_COMPUTE=2'd2, ST_DONE=2'd3.
  - Default DATA_WIDTH.
- Pointer width = $clog2(ROWS), derived locally.
- One natural sub-module: onehot_dec (binary pointer → ROWS-bit one-hot, gated by a fire input).
- Testbench instantiates wbuf_load_ctrl plus ROWS DFF instances to check captured data.

Test Plan:
- Basic job, ROWS=4, comp_len=3, in_valid held high, words 3,4,8,9:
  - row_en sequence 0001,0010,0100,1000 on consecutive cycles.
  - DFF q = 3,4,8,9.
  - comp_en high exactly 3 cycles, then done pulse of 1 cycle, then busy=0.
- Bubbled input, in_valid toggling 1,0,0,1,1,0,1:
  - row_en=0 and pointer holds during the 0 cycles.
  - Exactly 4 enables total.
  - COMPUTE entered the cycle after the 4th transfer.
- Zero-length job, comp_len=0:
  - After the 4th transfer, state goes DONE directly.
  - comp_en never asserts; done pulses once.
- Abort in LOAD after 2 transfers:
  - Next cycle busy=0, no done.
  - Rows 0,1 hold their data, rows 2,3 unchanged.
  - A following job starts loading at row 0 (row_en=0001).
- Reset mid-COMPUTE (rst=1 for 1 cycle at counter=1, comp_len=5):
  - All outputs 0 next cycle.
  - A start during rst is ignored.
  - A new start afterwards runs a full 5-cycle window.
- start held high through DONE:
  - Only one job per IDLE sample.
  - comp_len change after start does not alter the window length.
